// File: rtl/capture_if.sv
// Capture controller bus: command, sample strobe,
// trigger handshake and sample RAM write port.
interface capture_if #(
  parameter int ADDR_W = 9
);
  logic              run;
  logic              clr_done;
  logic [ADDR_W-1:0] trig_pos;
  logic              wrt_smpl;
  logic              triggered;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;

  modport master (
    input  run, clr_done, trig_pos,
    input  wrt_smpl, triggered,
    output armed, set_capture_done,
    output capture_done, we,
    output waddr, trig_addr
  );

  modport slave (
    output run, clr_done, trig_pos,
    output wrt_smpl, triggered,
    input  armed, set_capture_done,
    input  capture_done, we,
    input  waddr, trig_addr
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture controller: pre-trigger fill, arm,
// post-trigger count, capture-done status.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input logic       clk,
  input logic       rst,
  capture_if.master bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W:0]   r_smpl_cnt;
  logic              r_armed;
  logic              r_set_done;
  logic              r_capture_done;

  logic              w_we;
  logic [ADDR_W:0]   w_smpl_inc;
  logic [ADDR_W:0]   w_pre_target;
  logic [ADDR_W-1:0] w_post_inc;
  logic              w_pre_hit;
  logic              w_post_hit;
  logic              w_entry_done;

  // Write strobe, counter compares and next state
  always_comb begin
    w_next       = r_state;
    w_we         = 1'b0;
    w_smpl_inc   = r_smpl_cnt + (ADDR_W+1)'(1);
    w_pre_target = (ADDR_W+1)'(DEPTH)
                 - {1'b0, bus.trig_pos};
    w_post_inc   = r_post_cnt + ADDR_W'(1);
    w_pre_hit    = 1'b0;
    w_post_hit   = 1'b0;
    w_entry_done = 1'b0;

    if (r_state == S_PRE   ||
        r_state == S_ARMED ||
        r_state == S_POST)
      w_we = bus.wrt_smpl;

    w_pre_hit  = w_we
               && (w_smpl_inc == w_pre_target);
    w_post_hit = w_we
               && (w_post_inc == bus.trig_pos);

    case (r_state)
      S_IDLE: begin
        if (bus.run)
          w_next = S_PRE;
      end
      S_PRE: begin
        if (w_pre_hit)
          w_next = S_ARMED;
      end
      S_ARMED: begin
        if (bus.triggered) begin
          if (bus.trig_pos == '0)
            w_next = S_DONE;
          else
            w_next = S_POST;
        end
      end
      S_POST: begin
        if (w_post_hit)
          w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.run)
          w_next = S_PRE;
        else if (bus.clr_done)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    w_entry_done = (w_next == S_DONE)
                && (r_state != S_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Address, counters, trigger address and status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr        <= '0;
      r_trig_addr    <= '0;
      r_post_cnt     <= '0;
      r_smpl_cnt     <= '0;
      r_armed        <= 1'b0;
      r_set_done     <= 1'b0;
      r_capture_done <= 1'b0;
    end else begin
      r_armed    <= (w_next == S_ARMED)
                 || (w_next == S_POST);
      r_set_done <= w_entry_done;
      if (w_entry_done)
        r_capture_done <= 1'b1;
      if (w_we)
        r_waddr <= r_waddr + ADDR_W'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.run) begin
            r_waddr        <= '0;
            r_smpl_cnt     <= '0;
            r_capture_done <= 1'b0;
          end
        end
        S_PRE: begin
          if (w_we)
            r_smpl_cnt <= w_smpl_inc;
        end
        S_ARMED: begin
          if (bus.triggered) begin
            r_trig_addr <= r_waddr
                         + ADDR_W'(w_we);
            r_post_cnt  <= '0;
          end
        end
        S_POST: begin
          if (w_we)
            r_post_cnt <= w_post_inc;
        end
        S_DONE: begin
          if (bus.run) begin
            r_waddr        <= '0;
            r_smpl_cnt     <= '0;
            r_capture_done <= 1'b0;
          end else if (bus.clr_done) begin
            r_capture_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.we               = w_we;
  assign bus.waddr            = r_waddr;
  assign bus.trig_addr        = r_trig_addr;
  assign bus.armed            = r_armed;
  assign bus.set_capture_done = r_set_done;
  assign bus.capture_done     = r_capture_done;
endmodule
